// File: rtl/mem_req_arbiter_pkg.sv
// Shared constants for the CPU memory-request path: arbitration modes,
// transfer size encodings and fixed channel index assignments.
package mem_bus_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam int CH_DATA = 0;
  localparam int CH_INST = 1;

  // Tag width for a channel index; a single channel still needs one bit.
  function automatic int tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Channel-side and bus-side handshake bundles for mem_req_arbiter.
// master drives the request fields, slave returns the handshakes/data.
interface mem_ch_if #(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
);
  logic [NCH-1:0]        ch_req;
  logic [NCH-1:0]        ch_wr;
  logic [2*NCH-1:0]      ch_size;
  logic [NCH*DW/8-1:0]   ch_wstrb;
  logic [NCH*AW-1:0]     ch_addr;
  logic [NCH*DW-1:0]     ch_wdata;
  logic [NCH-1:0]        ch_addr_ok;
  logic [NCH-1:0]        ch_data_ok;
  logic [DW-1:0]         ch_rdata;

  modport master (
    output ch_req, ch_wr, ch_size, ch_wstrb, ch_addr, ch_wdata,
    input  ch_addr_ok, ch_data_ok, ch_rdata
  );

  modport slave (
    input  ch_req, ch_wr, ch_size, ch_wstrb, ch_addr, ch_wdata,
    output ch_addr_ok, ch_data_ok, ch_rdata
  );
endinterface

interface mem_bus_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            bus_req;
  logic            bus_wr;
  logic [1:0]      bus_size;
  logic [DW/8-1:0] bus_wstrb;
  logic [AW-1:0]   bus_addr;
  logic [DW-1:0]   bus_wdata;
  logic            bus_addr_ok;
  logic            bus_data_ok;
  logic [DW-1:0]   bus_rdata;

  modport master (
    output bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport slave (
    input  bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/mem_req_arbiter_fifo.sv
// In-order tag FIFO: remembers which channel owns each outstanding bus
// transaction so responses can be routed back.
module req_tag_fifo #(
  parameter  int DEPTH = 4,
  parameter  int TW    = 1,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic          pop,
  input  logic [TW-1:0] din,
  output logic [TW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [TW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Tag storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Merges NCH CPU memory channels onto one split-handshake bus, holding a
// grant until its address handshake and routing responses back in order.
module mem_req_arbiter
  import mem_bus_pkg::*;
#(
  parameter  int NCH      = 2,
  parameter  int DEPTH    = 4,
  parameter  int AW       = 32,
  parameter  int DW       = 32,
  parameter  int ARB_MODE = ARB_FIXED,
  localparam int TW       = tag_w(NCH),
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  mem_ch_if.slave       ch,
  mem_bus_if.master     bus,
  output logic [CW-1:0] outstanding,
  output logic          proto_err
);

  logic          lock_vld;
  logic [TW-1:0] lock_idx;
  logic [TW-1:0] rr_ptr;
  logic [TW-1:0] grant;
  logic [TW-1:0] next_rr;
  logic [TW-1:0] head;
  logic          sel_req;
  logic          hs;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  int            idx;
  int            gi;

  always_comb begin
    grant = '0;
    idx   = 0;
    if (lock_vld) begin
      grant = lock_idx;
    end else if (ARB_MODE == ARB_RR) begin
      // Scan downward so the nearest requester at/after rr_ptr wins last.
      for (int k = NCH - 1; k >= 0; k--) begin
        idx = (int'(rr_ptr) + k) % NCH;
        if (ch.ch_req[idx]) grant = TW'(idx);
      end
    end else begin
      for (int k = NCH - 1; k >= 0; k--) begin
        if (ch.ch_req[k]) grant = TW'(k);
      end
    end
  end

  always_comb begin
    gi            = int'(grant);
    sel_req       = ch.ch_req[grant];
    bus.bus_req   = sel_req & ~fifo_full;
    bus.bus_wr    = ch.ch_wr[grant];
    bus.bus_size  = ch.ch_size[gi*2 +: 2];
    bus.bus_wstrb = ch.ch_wstrb[gi*(DW/8) +: DW/8];
    bus.bus_addr  = ch.ch_addr[gi*AW +: AW];
    bus.bus_wdata = ch.ch_wdata[gi*DW +: DW];
    hs            = bus.bus_req & bus.bus_addr_ok;
    pop           = bus.bus_data_ok & ~fifo_empty;
    next_rr       = TW'((gi + 1) % NCH);
  end

  always_comb begin
    ch.ch_addr_ok        = '0;
    ch.ch_data_ok        = '0;
    ch.ch_addr_ok[grant] = hs;
    ch.ch_data_ok[head]  = pop;
    ch.ch_rdata          = bus.bus_rdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_vld  <= 1'b0;
      lock_idx  <= '0;
      rr_ptr    <= '0;
      proto_err <= 1'b0;
    end else begin
      // A locked channel that withdraws its request simply loses the lock.
      if (hs) begin
        lock_vld <= 1'b0;
      end else if (lock_vld && !ch.ch_req[lock_idx]) begin
        lock_vld <= 1'b0;
      end else if (bus.bus_req && !bus.bus_addr_ok) begin
        lock_vld <= 1'b1;
        lock_idx <= grant;
      end
      if (hs && (ARB_MODE == ARB_RR)) rr_ptr <= next_rr;
      if (bus.bus_data_ok && fifo_empty) proto_err <= 1'b1;
    end
  end

  req_tag_fifo #(
    .DEPTH (DEPTH),
    .TW    (TW)
  ) u_tag_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (hs),
    .pop    (pop),
    .din    (grant),
    .dout   (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (outstanding)
  );

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Parametrised request/response arbiter that merges NCH CPU memory channels (instruction fetch, data access, future cache-refill ports) onto one shared SRAM-like bus with split address/data handshakes. It sits between the pipeline stages and the memory port in the CPU top, in place of direct SRAM wiring with always-ready handshakes. It tracks up to DEPTH outstanding transactions in order and routes each returning response to its originating channel.

## Interface
- NCH, 2: number of requester channels; channel 0 = data, channel 1 = inst by convention.
- DEPTH, 4: maximum outstanding transactions; power of two, ≥2.
- AW, 32: address width.
- DW, 32: data width; wstrb width is DW/8.
- ARB_MODE, 0: 0 = fixed priority (lowest index wins), 1 = round-robin.
- clk  in  1  clock.
- resetn  in  1  reset; asynchronous, active-low.
- ch_req  in  NCH  per-channel request valid.
- ch_wr  in  NCH  per-channel write flag.
- ch_size  in  2*NCH  per-channel size: 0 byte, 1 half, 2 word.
- ch_wstrb  in  NCH*DW/8  per-channel byte strobes.
- ch_addr  in  NCH*AW  per-channel address.
- ch_wdata  in  NCH*DW  per-channel write data.
- ch_addr_ok  out  NCH  request accepted, one-hot or zero.
- ch_data_ok  out  NCH  response returned, one-hot or zero.
- ch_rdata  out  DW  read data, valid with any ch_data_ok bit.
- bus_req, bus_wr, bus_size[1:0], bus_wstrb, bus_addr, bus_wdata  out  shared bus request fields.
- bus_addr_ok  in  1  bus accepts request this cycle.
- bus_data_ok  in  1  bus returns response this cycle; one per accepted request, in order.
- bus_rdata  in  DW  response data.
- outstanding  out  $clog2(DEPTH)+1  accepted-but-unanswered count.
- proto_err  out  1  sticky: bus_data_ok seen with nothing outstanding.

## Operation
- Grant: combinational choice among ch_req when no lock held; fixed mode picks lowest index; RR mode picks first requester at or after rr_ptr, wrapping.
- Lock: if bus_req and !bus_addr_ok, the granted index is registered and held; the bus fields keep tracking only that channel until its handshake. A locked channel that drops ch_req is a protocol violation; the lock is released and no transaction is pushed.
- Issue: bus_req = selected ch_req & !fifo_full. Bus fields mux from the granted channel; bus_req is 0 when no channel requests.
- Handshake: ch_addr_ok[g] = bus_req & bus_addr_ok for granted g. On handshake, push g into the tag FIFO and clear the lock; RR mode sets rr_ptr = (g+1) mod NCH.
- Response: on bus_data_ok with FIFO non-empty, ch_data_ok[head] = 1, ch_rdata = bus_rdata, pop. Writes also receive data_ok with ch_rdata ignored.
- Empty + bus_data_ok: all ch_data_ok low, FIFO unchanged, proto_err set until reset.
- Full: no issue, even when a pop occurs in the same cycle.
- Simultaneous push and pop when not full: count unchanged, both take effect.

## Timing
- Request path: combinational ch_req → bus_req, zero cycles. Response path: combinational bus_data_ok → ch_data_ok, zero cycles.
- Earliest response to a given request is the cycle after its addr_ok; same-cycle data_ok refers to an older transaction.
- Reset (async assert, sync-to-clk deassert handled upstream): FIFO empty, outstanding = 0, lock clear, rr_ptr = 0, proto_err = 0. Hence bus_req = 0 and ch_addr_ok = ch_data_ok = 0 whenever ch_req = 0 and bus_data_ok = 0.
- Reset mid-operation drops all outstanding tags. A stale bus_data_ok after reset sets proto_err, and the bench must expect that.
- FIFO pointers are $clog2(DEPTH) bits and wrap naturally. The count is one bit wider to distinguish full from empty.

## Structure
- The shared package `mem_bus_pkg` holds the ARB_MODE constants, size encodings (SIZE_B/H/W), and the channel index assignments (CH_DATA = 0, CH_INST = 1).
- Sub-module `req_tag_fifo`: synchronous FIFO of $clog2(NCH)-bit tags, DEPTH entries, push/pop/full/empty/count. It is instantiated once.
- The arbiter and lock logic stay in the top of the block.

## Test plan
- Single read, NCH=2: ch_req=01, addr 0x1C000000, bus_addr_ok same cycle, data_ok 2 cycles later with 0xDEADBEEF → ch_addr_ok=01 for one cycle, then ch_data_ok=01 and ch_rdata=0xDEADBEEF, outstanding 1→0.
- Lock hold: ch_req=10, bus_addr_ok low 3 cycles, ch_req becomes 11 in cycle 2 → bus_addr stays on channel 1 until accepted; channel 0 is granted on the next cycle.
- Round-robin, ARB_MODE=1: both channels request continuously with addr_ok every cycle → grants alternate 0,1,0,1; fixed mode → channel 0 always wins.
- Full: DEPTH=4, accept 4 requests, no data_ok → bus_req = 0 and outstanding = 4; after one data_ok, issue resumes on the next cycle and responses return in order of tags 0,1,0,1.
- Error and reset: data_ok with empty FIFO → proto_err = 1 and no ch_data_ok; assert resetn low mid-burst with 2 outstanding → outstanding = 0, proto_err = 0 immediately.
